seq_det_ctrl: RTL and testbench

//   Run-time configurable serial pattern-detection controller. Accepts a pattern/length/target

---
 rtl/seq_det_ctrl_if.sv | 24 ++
 rtl/seq_det_ctrl.sv | 114 +++++++++++
 tb/tb_seq_det_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_ctrl_if.sv
// Configuration handshake and serial stream bundle for seq_det_ctrl.
interface seq_det_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic               cfg_err;
  logic               seq_valid;
  logic               seq_bit;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_target, seq_valid, seq_bit,
    input  cfg_ready, cfg_err
  );
  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_target, seq_valid, seq_bit,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Run-time configurable serial pattern detector: overlapping matches, Mealy tick,
// saturating hit counter and stop after a programmed number of matches.
module seq_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_det_ctrl_if.slave    bus,
  input  logic             start,
  input  logic             abort,
  output logic             tick,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  typedef struct packed {
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic [CNT_W-1:0]   target;
  } cfg_t;

  state_t             state, state_nxt;
  cfg_t               cfg, cfg_nxt;
  logic [MAX_LEN-1:0] history, hist_nxt;
  logic [LEN_W-1:0]   fill, fill_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               err_q, err_nxt;

  logic               len_ok, fill_ok, hit;
  logic [MAX_LEN-1:0] window, mask;

  assign bus.cfg_ready = (state != RUN);
  assign bus.cfg_err   = err_q;
  assign busy          = (state == RUN);
  assign done          = (state == DONE);

  assign len_ok  = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
  // Window is the newest MAX_LEN bits including the bit arriving this cycle.
  assign window  = {history[MAX_LEN-2:0], bus.seq_bit};
  assign mask    = ~({MAX_LEN{1'b1}} << cfg.len);
  assign fill_ok = ({1'b0, fill} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, cfg.len};
  assign hit     = bus.seq_valid && fill_ok && (((window ^ cfg.pattern) & mask) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cfg       <= '0;
      history   <= '0;
      fill      <= '0;
      match_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg       <= cfg_nxt;
      history   <= hist_nxt;
      fill      <= fill_nxt;
      match_cnt <= cnt_nxt;
      err_q     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cfg_nxt   = cfg;
    hist_nxt  = history;
    fill_nxt  = fill;
    cnt_nxt   = match_cnt;
    err_nxt   = 1'b0;
    tick      = 1'b0;
    if (bus.cfg_valid && bus.cfg_ready) begin
      // A rejected config freezes everything for that cycle, including start/abort.
      if (!len_ok) begin
        err_nxt = 1'b1;
      end else begin
        cfg_nxt   = '{pattern: bus.cfg_pattern, len: bus.cfg_len, target: bus.cfg_target};
        cnt_nxt   = '0;
        state_nxt = ARMED;
      end
    end else begin
      case (state)
        ARMED, DONE: begin
          if (abort) begin
            state_nxt = ARMED;
          end else if (start) begin
            state_nxt = RUN;
            hist_nxt  = '0;
            fill_nxt  = '0;
            cnt_nxt   = '0;
          end
        end
        RUN: begin
          if (abort) begin
            state_nxt = ARMED;
          end else if (bus.seq_valid) begin
            hist_nxt = window;
            if (fill != LEN_W'(MAX_LEN)) fill_nxt = fill + 1'b1;
            if (hit) begin
              tick = 1'b1;
              if (match_cnt != '1) begin
                cnt_nxt = match_cnt + 1'b1;
                if ((cfg.target != '0) && (cnt_nxt == cfg.target)) state_nxt = DONE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with a tick/cfg_err scoreboard fed by the stimulus.
module tb_seq_det_ctrl;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int K_TICK  = 0;
  localparam int K_ERR   = 1;

  typedef struct {
    int kind;
    int id;
    int cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             tick;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;

  seq_det_ctrl_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .start(start), .abort(abort),
    .tick(tick), .match_cnt(match_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   errors  = 0;
  int   cur_id  = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int cnt);
    exp_t e;
    e.kind = kind; e.id = cur_id; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic cfg(input int pat, input int len, input int tgt, input bit bad);
    bus.cfg_valid   = 1'b1;
    bus.cfg_pattern = MAX_LEN'(pat);
    bus.cfg_len     = LEN_W'(len);
    bus.cfg_target  = CNT_W'(tgt);
    if (bad) push(K_ERR, 0);
    cycle();
    bus.cfg_valid = 1'b0;
  endtask

  // One valid bit; exp_cnt >= 0 means a tick is expected with that pre-increment count.
  task automatic send(input bit b, input int exp_cnt, input bit ab);
    cur_id++;
    bus.seq_valid = 1'b1;
    bus.seq_bit   = b;
    abort         = ab;
    if (exp_cnt >= 0) push(K_TICK, exp_cnt);
    cycle();
    bus.seq_valid = 1'b0;
    abort         = 1'b0;
  endtask

  task automatic gap();
    bus.seq_valid = 1'b0;
    bus.seq_bit   = 1'b1;
    cycle();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    cycle();
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every output event must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && tick) begin
      if (exp_q.size() == 0) begin
        check("tick_spurious", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("tick_kind", K_TICK, e.kind);
        check("tick_bit_id", cur_id, e.id);
        check("tick_cnt", int'(match_cnt), e.cnt);
      end
    end
    if (!rst && bus.cfg_err) begin
      if (exp_q.size() == 0) begin
        check("cfg_err_spurious", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("cfg_err_kind", K_ERR, e.kind);
      end
    end
  end

  initial begin
    bus.cfg_valid = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_target = '0;
    bus.seq_valid = 1'b0; bus.seq_bit = 1'b0;
    cycle(); cycle();
    check("rst_cfg_ready", bus.cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_tick", tick, 0);
    rst = 1'b0;
    cycle();

    // 1: overlapping 101, target 2
    cfg('b101, 3, 2, 1'b0);
    check("t1_armed_ready", bus.cfg_ready, 1);
    pulse_start();
    check("t1_busy", busy, 1);
    check("t1_ready_run", bus.cfg_ready, 0);
    send(1, -1, 0); send(0, -1, 0); send(1, 0, 0);
    check("t1_cnt1", match_cnt, 1);
    send(0, -1, 0); send(1, 1, 0);
    check("t1_done", done, 1);
    check("t1_cnt2", match_cnt, 2);
    check("t1_busy_off", busy, 0);
    send(1, -1, 0); send(0, -1, 0); send(1, -1, 0);
    check("t1_cnt_hold", match_cnt, 2);
    drain("t1_drain");

    // 2: illegal lengths leave IDLE untouched
    rst = 1'b1; cycle(); rst = 1'b0; cycle();
    cfg('b1, 0, 0, 1'b1);
    cycle();
    cfg('b1, 9, 0, 1'b1);
    cycle();
    check("t2_ready", bus.cfg_ready, 1);
    check("t2_cfg_err_low", bus.cfg_err, 0);
    pulse_start();
    check("t2_idle_start", busy, 0);
    drain("t2_drain");

    // 3: 1100 with stalls, target 0
    cfg('b1100, 4, 0, 1'b0);
    pulse_start();
    check("t3_busy", busy, 1);
    send(1, -1, 0); gap(); send(1, -1, 0); gap(); gap();
    send(0, -1, 0); gap(); send(0, 0, 0);
    check("t3_cnt", match_cnt, 1);
    check("t3_busy_hold", busy, 1);
    check("t3_done", done, 0);
    drain("t3_drain");

    // 4: abort on a matching last bit, then restart with fill cleared
    send(1, -1, 0); send(1, -1, 0); send(0, -1, 0); send(0, -1, 1);
    check("t4_cnt_kept", match_cnt, 1);
    check("t4_armed", bus.cfg_ready, 1);
    check("t4_busy", busy, 0);
    pulse_start();
    check("t4_cnt_clr", match_cnt, 0);
    send(0, -1, 0);
    send(1, -1, 0); send(1, -1, 0); send(0, -1, 0); send(0, 0, 0);
    check("t4_cnt", match_cnt, 1);
    drain("t4_drain");
    abort = 1'b1; cycle(); abort = 1'b0;

    // 5: async reset mid-run at match_cnt=5
    cfg('b11, 2, 0, 1'b0);
    pulse_start();
    send(1, -1, 0);
    for (int i = 0; i < 5; i++) send(1, i, 0);
    check("t5_cnt5", match_cnt, 5);
    drain("t5_drain");
    rst = 1'b1;
    bus.seq_valid = 1'b1; bus.seq_bit = 1'b1;
    #1;
    check("t5_rst_cnt", match_cnt, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_tick", tick, 0);
    check("t5_rst_ready", bus.cfg_ready, 1);
    bus.seq_valid = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    pulse_start();
    check("t5_start_ignored", busy, 0);

    // 6: len=1, 255 hits saturate into DONE
    cfg('b1, 1, 255, 1'b0);
    pulse_start();
    for (int i = 0; i < 255; i++) send(1, i, 0);
    check("t6_done", done, 1);
    check("t6_cnt", match_cnt, 255);
    send(1, -1, 0); send(1, -1, 0);
    check("t6_cnt_hold", match_cnt, 255);
    drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
